// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the bus sources and the bus arbiter
interface bus_arbiter_if #(parameter int N_SRC = 24);
  logic [N_SRC-1:0] req;
  logic             lock;
  logic [31:0]      grant;
  logic [4:0]       grant_id;
  logic             busy;
  logic             preempt;
  modport master (output req, lock, input grant, grant_id, busy, preempt);
  modport slave (input req, lock, output grant, grant_id, busy, preempt);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner sequencing of the shared datapath bus with turnaround and hold limit
module bus_arbiter #(
  parameter int N_SRC    = 24,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic          clock,
  input logic          clear,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t            state, state_n;
  logic [31:0]       grant_q, grant_n;
  logic [4:0]        id_q, id_n, ptr, ptr_n, sel, idx;
  logic              busy_q, busy_n, pre_q, pre_n, sel_ok, elig;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [31:0]       req_w;
  assign req_w        = 32'(bus.req);
  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy     = busy_q;
  assign bus.preempt  = pre_q;
  // pick the first requester after the pointer; descending scan so the nearest one wins
  always_comb begin
    sel_ok = 1'b0;
    sel    = '0;
    idx    = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = 5'((int'(ptr) + k) % N_SRC);
      if (req_w[idx]) begin
        sel_ok = 1'b1;
        sel    = idx;
      end
    end
  end
  // preemption needs an expired hold, no lock, and a competitor other than the owner
  assign elig = (cnt >= CNT_W'(MAX_HOLD)) && !bus.lock && |(req_w & ~grant_q);
  // next state and next registered outputs
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    id_n    = id_q;
    busy_n  = busy_q;
    pre_n   = 1'b0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      OWN: begin
        if (!req_w[id_q] || elig) begin
          state_n = TURN;
          grant_n = '0;
          id_n    = '0;
          busy_n  = 1'b0;
          cnt_n   = '0;
          pre_n   = req_w[id_q];
        end else begin
          cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      IDLE, TURN: begin
        state_n = sel_ok ? OWN : IDLE;
        grant_n = sel_ok ? (32'd1 << sel) : '0;
        id_n    = sel_ok ? sel : '0;
        busy_n  = sel_ok;
        ptr_n   = sel_ok ? sel : ptr;
        cnt_n   = sel_ok ? CNT_W'(1) : '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
      ptr     <= 5'(N_SRC - 1);
      cnt     <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      id_q    <= id_n;
      busy_q  <= busy_n;
      pre_q   <= pre_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end
endmodule
